// File: rtl/tetris_piece_fsm.sv
// tetris_piece_fsm: active falling-block controller with gravity timing, player moves,
// LFSR next-piece preview and level speed-up.
module tetris_piece_fsm #(
  parameter int          X_W          = 5,
  parameter int          Y_W          = 5,
  parameter int          SPAWN_X      = 3,
  parameter int          CNT_W        = 27,
  parameter int          DROP_TICKS   = 100_000_000,
  parameter int          MIN_TICKS    = 10_000_000,
  parameter int          STEP_TICKS   = 10_000_000,
  parameter int          LEVEL_PIECES = 20,
  parameter int          FAST_SHIFT   = 1,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           i_start,
  input  logic           i_up,
  input  logic           i_down,
  input  logic           i_left,
  input  logic           i_right,
  input  logic           i_eu,
  input  logic           i_ed,
  input  logic           i_el,
  input  logic           i_er,
  input  logic           i_edrop,
  input  logic           i_overflow,
  input  logic           i_refresh_done,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic [2:0]     o_type,
  output logic [1:0]     o_dir,
  output logic [2:0]     o_next_type,
  output logic [3:0]     o_level,
  output logic           o_refresh,
  output logic           o_fail
);
  localparam int SC_W = $clog2(LEVEL_PIECES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_FALL, S_WAIT, S_FAIL} state_t;

  state_t           r_state, w_state;
  logic [X_W-1:0]   r_x, w_x;
  logic [Y_W-1:0]   r_y, w_y;
  logic [2:0]       r_type, w_type, r_next, w_next;
  logic [1:0]       r_dir, w_dir;
  logic [3:0]       r_level, w_level;
  logic             r_refresh, w_refresh, r_fail, w_fail, r_mode, w_mode;
  logic [15:0]      r_lfsr, w_lfsr;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_period, w_period, w_p;
  logic [SC_W-1:0]  r_spawns, w_spawns;
  logic             w_tick;

  assign w_p    = r_mode ? r_period >> FAST_SHIFT : r_period;
  assign w_tick = (r_state == S_FALL) && (r_cnt == w_p - CNT_W'(1));

  always_comb begin
    w_state   = r_state;
    w_x       = r_x;
    w_y       = r_y;
    w_type    = r_type;
    w_dir     = r_dir;
    w_next    = r_next;
    w_level   = r_level;
    w_refresh = 1'b0;
    w_fail    = r_fail;
    w_mode    = r_mode;
    w_cnt     = r_cnt;
    w_period  = r_period;
    w_spawns  = r_spawns;
    w_lfsr    = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    case (r_state)
      S_IDLE: w_state = i_start ? S_SPAWN : S_IDLE;
      S_SPAWN: begin
        w_x      = X_W'(SPAWN_X);
        w_y      = '0;
        w_dir    = '0;
        w_type   = r_next;
        w_next   = 3'(r_lfsr % 16'd7) + 3'd1;
        w_mode   = 1'b0;
        w_cnt    = '0;
        w_spawns = r_spawns + SC_W'(1);
        if (r_spawns + SC_W'(1) == SC_W'(LEVEL_PIECES)) begin
          w_spawns = '0;
          w_level  = (r_level == 4'd15) ? r_level : r_level + 4'd1;
          w_period = (r_period >= CNT_W'(MIN_TICKS + STEP_TICKS)) ? r_period - CNT_W'(STEP_TICKS)
                                                                   : CNT_W'(MIN_TICKS);
        end
        w_state  = S_FALL;
      end
      S_FALL: begin
        if (w_tick) begin
          // gravity owns the tick cycle; key pulses arriving now are dropped
          w_cnt = '0;
          if (i_edrop) w_y = r_y + Y_W'(1);
          else if (i_overflow) begin
            w_fail  = 1'b1;
            w_state = S_FAIL;
          end else begin
            w_refresh = 1'b1;
            w_state   = S_WAIT;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
          if (i_up && i_eu) w_dir = r_dir + 2'd1;
          if (i_left ^ i_right)
            w_x = (i_left && i_el) ? r_x - X_W'(1) : (i_right && i_er) ? r_x + X_W'(1) : r_x;
          if (i_down && i_ed && !r_mode) begin
            w_mode = 1'b1;
            w_cnt  = '0;
          end
        end
      end
      S_WAIT: w_state = i_refresh_done ? S_SPAWN : S_WAIT;
      default: w_state = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_x       <= X_W'(SPAWN_X);
      r_y       <= '0;
      r_type    <= '0;
      r_dir     <= '0;
      r_next    <= 3'd1;
      r_level   <= '0;
      r_refresh <= 1'b0;
      r_fail    <= 1'b0;
      r_mode    <= 1'b0;
      r_lfsr    <= SEED;
      r_cnt     <= '0;
      r_period  <= CNT_W'(DROP_TICKS);
      r_spawns  <= '0;
    end else begin
      r_state   <= w_state;
      r_x       <= w_x;
      r_y       <= w_y;
      r_type    <= w_type;
      r_dir     <= w_dir;
      r_next    <= w_next;
      r_level   <= w_level;
      r_refresh <= w_refresh;
      r_fail    <= w_fail;
      r_mode    <= w_mode;
      r_lfsr    <= w_lfsr;
      r_cnt     <= w_cnt;
      r_period  <= w_period;
      r_spawns  <= w_spawns;
    end
  end

  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_type      = r_type;
  assign o_dir       = r_dir;
  assign o_next_type = r_next;
  assign o_level     = r_level;
  assign o_refresh   = r_refresh;
  assign o_fail      = r_fail;
endmodule
